// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
package vga_timing_pkg;

  // Default 640x480@60 mode (25.175 MHz nominal pixel rate)
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Sync polarity encoding: value the sync pin takes while active
  localparam bit POL_ACTIVE_HIGH = 1'b1;
  localparam bit POL_ACTIVE_LOW  = 1'b0;

  // Total period of one axis
  function automatic int total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping counter 0..LIMIT-1 with a programmable reset value, exposing
// both the registered count and its next-state value plus a wrap carry.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW      = 10,
  parameter int LIMIT   = 800,
  parameter int RST_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_d_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] RST  = CW'(RST_VAL);

  logic [CW-1:0] cnt_q, cnt_d;

  // Carry fires on the increment that takes the count from LAST back to 0
  assign wrap_o  = inc_i && (cnt_q == LAST);
  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

  // Next-state: advance on inc_i, wrap at LAST
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= RST;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing.sv
// Parametrised VGA timing generator: pixel enable, sync/blank, display
// position, look-ahead fetch position, frame/line strobes, frame counter.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_POL      = POL_ACTIVE_LOW,
  parameter bit V_POL      = POL_ACTIVE_LOW,
  parameter int CLK_DIV    = 2,
  parameter int FETCH_LEAD = 2,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic [CW-1:0] posx,
  output logic [CW-1:0] posy,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid,
  output logic          frame_start,
  output logic          line_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Fetch pair starts FETCH_LEAD pixels past the display reset point,
  // carrying into y if that crosses the end of the line.
  localparam int FX_RAW = H_VISIBLE + FETCH_LEAD;
  localparam int FX_RST = FX_RAW % H_TOTAL;
  localparam int FY_RST = (V_VISIBLE + FX_RAW / H_TOTAL) % V_TOTAL;

  // Decode thresholds carry one spare bit so an end bound equal to 2**CW fits
  localparam logic [CW:0] HS_START = (CW+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CW:0] HS_END   = (CW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW:0] VS_START = (CW+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CW:0] VS_END   = (CW+1)'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW:0] H_VIS    = (CW+1)'(H_VISIBLE);
  localparam logic [CW:0] V_VIS    = (CW+1)'(V_VISIBLE);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_too_small
    $error("vga_timing: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end
  if (CLK_DIV < 1 || FETCH_LEAD < 0 || FETCH_LEAD >= H_TOTAL) begin : g_bad_param
    $error("vga_timing: CLK_DIV or FETCH_LEAD out of range");
  end

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] px_d, py_d, fx_d, fy_d;
  logic          px_wrap, py_wrap, fx_wrap, fy_wrap_unused;
  logic          hsync_q, vsync_q, blank_q, fvalid_q, fs_q, ls_q;
  logic          hsync_d, vsync_d, blank_d, fvalid_d, fs_d, ls_d;
  logic [7:0]    fc_q, fc_d;

  // Pixel divider: counts only while enabled, so a freeze resumes mid-pixel
  always_comb begin
    div_d = div_q;
    if (enable) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  // Divider register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_q <= '0;
    else        div_q <= div_d;
  end

  assign pix_tick = enable && (div_q == DIV_LAST) && reset;

  vga_axis_counter #(.CW(CW), .LIMIT(H_TOTAL), .RST_VAL(H_VISIBLE)) u_disp_x (
    .clk(clk), .rst_n_i(reset), .inc_i(pix_tick),
    .cnt_o(posx), .cnt_d_o(px_d), .wrap_o(px_wrap));

  vga_axis_counter #(.CW(CW), .LIMIT(V_TOTAL), .RST_VAL(V_VISIBLE)) u_disp_y (
    .clk(clk), .rst_n_i(reset), .inc_i(px_wrap),
    .cnt_o(posy), .cnt_d_o(py_d), .wrap_o(py_wrap));

  vga_axis_counter #(.CW(CW), .LIMIT(H_TOTAL), .RST_VAL(FX_RST)) u_fetch_x (
    .clk(clk), .rst_n_i(reset), .inc_i(pix_tick),
    .cnt_o(fetch_x), .cnt_d_o(fx_d), .wrap_o(fx_wrap));

  // The fetch frame wrap has no consumer; only its line carry matters
  vga_axis_counter #(.CW(CW), .LIMIT(V_TOTAL), .RST_VAL(FY_RST)) u_fetch_y (
    .clk(clk), .rst_n_i(reset), .inc_i(fx_wrap),
    .cnt_o(fetch_y), .cnt_d_o(fy_d), .wrap_o(fy_wrap_unused));

  // Decodes from next-state counters so registered outputs align with posx/posy
  always_comb begin
    hsync_d  = (({1'b0, px_d} >= HS_START) && ({1'b0, px_d} < HS_END)) ? H_POL : ~H_POL;
    vsync_d  = (({1'b0, py_d} >= VS_START) && ({1'b0, py_d} < VS_END)) ? V_POL : ~V_POL;
    blank_d  = ({1'b0, px_d} >= H_VIS) || ({1'b0, py_d} >= V_VIS);
    fvalid_d = ({1'b0, fx_d} < H_VIS) && ({1'b0, fy_d} < V_VIS);
    // Display y wrap happens exactly on the edge that enters (0,0)
    fs_d     = py_wrap;
    ls_d     = px_wrap && ({1'b0, py_d} < V_VIS);
    fc_d     = py_wrap ? fc_q + 8'd1 : fc_q;
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q  <= ~H_POL;
      vsync_q  <= ~V_POL;
      blank_q  <= 1'b1;
      fvalid_q <= 1'b0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
      fc_q     <= 8'd0;
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      blank_q  <= blank_d;
      fvalid_q <= fvalid_d;
      fs_q     <= fs_d;
      ls_q     <= ls_d;
      fc_q     <= fc_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign fetch_valid = fvalid_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign frame_count = fc_q;

endmodule
